// File: rtl/i2c_bit_sequencer.sv
// Command-driven I2C bit sequencer. Each command runs four quarter-phases of
// (div_q+1) clk cycles and drives registered SCL/SDA levels for START/STOP/WRITE/READ.
module i2c_bit_sequencer #(
  parameter int DIV_W = 8,
  parameter int CMD_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_q,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_wdata,
  output logic             cmd_ready,
  input  logic             sda_in,
  output logic             scl_out,
  output logic             sda_out,
  output logic             rd_valid,
  output logic             rd_data,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CMD_W-1:0] CMD_START = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_STOP  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(2);

  logic [0:0]       state;
  logic [1:0]       ph;
  logic [DIV_W-1:0] qc;
  logic [DIV_W-1:0] d_lat;
  logic [CMD_W-1:0] cmd_lat;
  logic             wdata_lat;
  logic             rd_sample;
  logic             ready_en;

  // Returns {scl, sda} for a command at a given quarter-phase.
  function automatic logic [1:0] phase_levels(input logic [CMD_W-1:0] c,
                                              input logic w,
                                              input logic [1:0] p);
    logic [1:0] lv;
    lv = 2'b11;
    case (c)
      CMD_START: begin
        case (p)
          2'd0:    lv = 2'b11;
          2'd1:    lv = 2'b11;
          2'd2:    lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (p)
          2'd0:    lv = 2'b00;
          2'd1:    lv = 2'b10;
          2'd2:    lv = 2'b11;
          default: lv = 2'b11;
        endcase
      end
      CMD_WRITE: lv = {(p == 2'd1) || (p == 2'd2), w};
      default:   lv = {(p == 2'd1) || (p == 2'd2), 1'b1};
    endcase
    return lv;
  endfunction

  // Handshake: a command is taken on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on internal state and enable, never on cmd_valid.
  assign cmd_ready = ready_en && (state == S_IDLE) && enable;
  assign busy      = (state == S_RUN);
  assign dbg_state = {state, ph};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ph        <= 2'd0;
      qc        <= '0;
      d_lat     <= '0;
      cmd_lat   <= '0;
      wdata_lat <= 1'b0;
      rd_sample <= 1'b0;
      ready_en  <= 1'b0;
      scl_out   <= 1'b1;
      sda_out   <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rd_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (cmd_valid && cmd_ready) begin
          state               <= S_RUN;
          ph                  <= 2'd0;
          qc                  <= '0;
          d_lat               <= div_q;
          cmd_lat             <= cmd;
          wdata_lat           <= cmd_wdata;
          {scl_out, sda_out}  <= phase_levels(cmd, cmd_wdata, 2'd0);
        end
      end else if (enable) begin
        if (qc == d_lat) begin
          qc <= '0;
          ph <= ph + 2'd1;
          if (ph == 2'd1) begin
            rd_sample <= sda_in;
          end
          // The last phase keeps its levels on the bus until the next accept.
          if (ph == 2'd3) begin
            state <= S_IDLE;
            if (cmd_lat != CMD_START && cmd_lat != CMD_STOP && cmd_lat != CMD_WRITE) begin
              rd_valid <= 1'b1;
              rd_data  <= rd_sample;
            end
          end else begin
            {scl_out, sda_out} <= phase_levels(cmd_lat, wdata_lat, ph + 2'd1);
          end
        end else begin
          qc <= qc + DIV_W'(1);
        end
      end
    end
  end

endmodule
